// File: rtl/memory_bist_pkg.sv
// memory_bist_pkg: FSM states, March C- element table and data backgrounds shared by the BIST controller
package memory_bist_pkg;
    typedef enum logic [2:0] {IDLE, WRITE, READ, CMP, DONE} state_t;
    localparam int NUM_ELEM = 6;
    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);
    localparam logic [7:0] DIR_DOWN = 8'b0001_1000;
    localparam logic BG0 = 1'b0;
    localparam logic BG1 = 1'b1;
endpackage

// File: rtl/memory_bist_addr_gen.sv
// memory_bist_addr_gen: up/down address counter; ports clk, reset, load/load_down (restart at 0 or top, latching direction), step, addr, last
module memory_bist_addr_gen #(
    parameter int ADDR_WIDTH = 16,
    parameter int RAM_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic down_d, down_q;
    always_comb begin
        down_d = load ? load_down : down_q;
        addr_d = load ? (load_down ? MAX_ADDR : '0) :
                 step ? (down_q ? addr_q - 1'b1 : addr_q + 1'b1) : addr_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            down_q <= down_d;
        end
    end
    assign addr = addr_q;
    assign last = down_q ? (addr_q == '0) : (addr_q == MAX_ADDR);
endmodule

// File: rtl/memory_bist_controller.sv
// memory_bist_controller: March C- BIST engine; ports clk, reset, start -> busy/done/pass/err_count/fail_addr/fail_element, drives mem_address/mem_data_input/mem_write_enable, reads mem_data_output
module memory_bist_controller
    import memory_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int RAM_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_input,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_output
);
    state_t state_d, state_q;
    logic [2:0] elem_d, elem_q, fe_d, fe_q;
    logic busy_d, busy_q, done_d, done_q, pass_d, pass_q, we_d, we_q;
    logic [15:0] err_d, err_q;
    logic [ADDR_WIDTH-1:0] fa_d, fa_q;
    logic [DATA_WIDTH-1:0] din_d, din_q;
    logic load, load_down, step, last, miss;
    memory_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .RAM_DEPTH(RAM_DEPTH)) u_addr (
        .clk(clk), .reset(reset), .load(load), .load_down(load_down),
        .step(step), .addr(mem_address), .last(last)
    );
    // Reads in odd elements expect background 0, in even elements background 1 (E5 reads 0)
    assign miss = mem_data_output != {DATA_WIDTH{elem_q[0] ? BG0 : BG1}};
    always_comb begin
        state_d = state_q;
        elem_d = elem_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        err_d = err_q;
        fa_d = fa_q;
        fe_d = fe_q;
        load = 1'b0;
        load_down = 1'b0;
        step = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = WRITE;
                elem_d = '0;
                busy_d = 1'b1;
                done_d = 1'b0;
                pass_d = 1'b0;
                err_d = '0;
                fa_d = '0;
                fe_d = '0;
                load = 1'b1;
            end
            WRITE: if (last) begin
                elem_d = elem_q + 3'd1;
                load = 1'b1;
                load_down = DIR_DOWN[elem_d];
                state_d = READ;
            end else begin
                step = 1'b1;
                state_d = (elem_q == '0) ? WRITE : READ;
            end
            READ: state_d = CMP;
            CMP: begin
                if (miss) begin
                    err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                    fa_d = (err_q == '0) ? mem_address : fa_q;
                    fe_d = (err_q == '0) ? elem_q : fe_q;
                end
                if (elem_q != LAST_ELEM) state_d = WRITE;
                else if (last) begin
                    state_d = DONE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_d == '0);
                    load = 1'b1;
                end else begin
                    step = 1'b1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
        we_d = (state_d == WRITE);
        din_d = we_d ? {DATA_WIDTH{elem_d[0] ? BG1 : BG0}} : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            elem_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q <= '0;
            fa_q <= '0;
            fe_q <= '0;
            we_q <= 1'b0;
            din_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q <= elem_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            err_q <= err_d;
            fa_q <= fa_d;
            fe_q <= fe_d;
            we_q <= we_d;
            din_q <= din_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;
    assign err_count = err_q;
    assign fail_addr = fa_q;
    assign fail_element = fe_q;
    assign mem_write_enable = we_q;
    assign mem_data_input = din_q;
endmodule

// File: tb/tb_memory_bist_controller.sv
// tb_memory_bist_controller: directed self-checking bench for the March C- BIST controller on a 16x8 memory model
module tb_memory_bist_controller;
    logic clk = 1'b0;
    logic reset, start;
    logic busy, done, pass, mem_write_enable;
    logic [15:0] err_count;
    logic [3:0] fail_addr, mem_address;
    logic [2:0] fail_element;
    logic [7:0] mem_data_input, mem_data_output;
    logic stuck5, corrupt;
    logic [7:0] mem [16];
    logic [7:0] rd_q;
    logic [3:0] log_addr [400];
    logic log_we [400];
    logic [7:0] log_din [400];
    logic done_at0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_bist_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_addr(fail_addr), .fail_element(fail_element),
        .mem_address(mem_address), .mem_data_input(mem_data_input),
        .mem_write_enable(mem_write_enable), .mem_data_output(mem_data_output)
    );

    always @(posedge clk) begin
        if (mem_write_enable)
            mem[mem_address] <= (stuck5 && mem_address == 4'd5) ? (mem_data_input | 8'h01) : mem_data_input;
        if (corrupt)
            mem[15] <= 8'hFF;
        rd_q <= mem[mem_address];
    end
    assign mem_data_output = rd_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int restart_at, input int corrupt_at, output int cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        done_at0 = done;
        cycles = 0;
        while (busy && cycles < 400) begin
            log_addr[cycles] = mem_address;
            log_we[cycles] = mem_write_enable;
            log_din[cycles] = mem_data_input;
            cycles++;
            start = (cycles == restart_at);
            corrupt = (cycles == corrupt_at);
            tick();
        end
        start = 1'b0;
        corrupt = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL reset_done_pass: got %b%b want 00", done, pass); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err: got %h want 0", err_count); end
        checks++; if (fail_addr !== 4'h0 || fail_element !== 3'h0) begin errors++; $display("FAIL reset_fail_info: got %h/%h want 0/0", fail_addr, fail_element); end
        checks++; if (mem_write_enable !== 1'b0 || mem_address !== 4'h0 || mem_data_input !== 8'h0) begin
            errors++; $display("FAIL reset_mem_port: got we=%b a=%h d=%h want 0/0/0", mem_write_enable, mem_address, mem_data_input); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL idle_quiet: got busy=%b we=%b want 0/0", busy, mem_write_enable); end
    endtask

    task automatic test_march_pass();
        int cyc, n, a;
        logic [3:0] ea [240];
        logic ew [240];
        logic [7:0] ed [240];
        n = 0;
        for (int i = 0; i < 16; i++) begin
            ea[n] = 4'(i); ew[n] = 1'b1; ed[n] = 8'h00; n++;
        end
        for (int e = 1; e <= 5; e++) begin
            for (int j = 0; j < 16; j++) begin
                a = (e == 3 || e == 4) ? 15 - j : j;
                ea[n] = 4'(a); ew[n] = 1'b0; ed[n] = 8'h00; n++;
                ea[n] = 4'(a); ew[n] = 1'b0; ed[n] = 8'h00; n++;
                if (e < 5) begin
                    ea[n] = 4'(a); ew[n] = 1'b1; ed[n] = (e % 2 == 1) ? 8'hFF : 8'h00; n++;
                end
            end
        end
        run(0, 0, cyc);
        checks++; if (cyc != 240) begin errors++; $display("FAIL pass_busy_len: got %0d want 240", cyc); end
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL pass_done: got done=%b pass=%b want 1/1", done, pass); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL pass_err: got %0d want 0", err_count); end
        checks++; if (mem_write_enable !== 1'b0 || mem_address !== 4'h0 || mem_data_input !== 8'h0) begin
            errors++; $display("FAIL pass_idle_port: got we=%b a=%h d=%h want 0/0/0", mem_write_enable, mem_address, mem_data_input); end
        for (int i = 0; i < 240; i++) begin
            checks++;
            if (log_addr[i] !== ea[i] || log_we[i] !== ew[i] || log_din[i] !== ed[i]) begin
                errors++;
                $display("FAIL seq[%0d]: got a=%h we=%b d=%h want a=%h we=%b d=%h", i, log_addr[i], log_we[i], log_din[i], ea[i], ew[i], ed[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        run(50, 0, cyc);
        checks++; if (done_at0 !== 1'b0) begin errors++; $display("FAIL restart_done_clear: got %b want 0", done_at0); end
        checks++; if (cyc != 240) begin errors++; $display("FAIL restart_len: got %0d want 240", cyc); end
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL restart_done: got done=%b pass=%b want 1/1", done, pass); end
    endtask

    task automatic test_stuck_bit();
        int cyc;
        stuck5 = 1'b1;
        run(0, 0, cyc);
        stuck5 = 1'b0;
        checks++; if (cyc != 240) begin errors++; $display("FAIL stuck_len: got %0d want 240", cyc); end
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL stuck_done: got done=%b pass=%b want 1/0", done, pass); end
        checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL stuck_err: got %0d want 3", err_count); end
        checks++; if (fail_addr !== 4'd5) begin errors++; $display("FAIL stuck_addr: got %0d want 5", fail_addr); end
        checks++; if (fail_element !== 3'd1) begin errors++; $display("FAIL stuck_elem: got %0d want 1", fail_element); end
    endtask

    task automatic test_corrupt();
        int cyc;
        run(0, 20, cyc);
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL corrupt_done: got done=%b pass=%b want 1/0", done, pass); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL corrupt_err: got %0d want 1", err_count); end
        checks++; if (fail_addr !== 4'd15) begin errors++; $display("FAIL corrupt_addr: got %0d want 15", fail_addr); end
        checks++; if (fail_element !== 3'd1) begin errors++; $display("FAIL corrupt_elem: got %0d want 1", fail_element); end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int wr = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_midrun_busy: got %b want 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || mem_write_enable !== 1'b0) begin errors++; $display("FAIL abort_edge: got busy=%b we=%b want 0/0", busy, mem_write_enable); end
        checks++; if (done !== 1'b0 || mem_address !== 4'h0) begin errors++; $display("FAIL abort_state: got done=%b a=%h want 0/0", done, mem_address); end
        repeat (5) begin
            tick();
            wr += (mem_write_enable === 1'b1) ? 1 : 0;
        end
        checks++; if (wr != 0) begin errors++; $display("FAIL abort_no_write: got %0d writes want 0", wr); end
        run(0, 0, cyc);
        checks++; if (cyc != 240) begin errors++; $display("FAIL fresh_len: got %0d want 240", cyc); end
        checks++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'h0) begin
            errors++; $display("FAIL fresh_pass: got done=%b pass=%b err=%0d want 1/1/0", done, pass, err_count); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stuck5 = 1'b0;
        corrupt = 1'b0;
        test_reset();
        test_march_pass();
        test_start_ignored();
        test_stuck_bit();
        test_corrupt();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
